fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 redirect  input  1  taken branch/jump; replaces the fetch PC.
REQ-005 redirect_pc  input  32  target address (PC + extended immediate); bits [1:0] SHALL be ignored and forced to 0.
REQ-006 stall  input  1  decode cannot accept; the decode register SHALL hold.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address, word-aligned.
REQ-009 imem_gnt  input  1  request accepted in the same cycle as imem_req.
REQ-010 imem_rvalid  input  1  response data valid; one response per grant, in order.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr_d  output  32  registered instruction to decode and immediate extension.
REQ-013 pc_d  output  32  address of instr_d.
REQ-014 pcplus4_d  output  32  pc_d + 4, modulo 2^32.
REQ-015 valid_d  output  1  instr_d/pc_d/pcplus4_d hold a valid instruction.

Function
REQ-016 FSM states SHALL be FETCH, WAIT, DROP and SKID; only one memory request SHALL be outstanding at any time.
REQ-017 FETCH: imem_req=1 unless valid_d && stall; imem_addr=fetch PC; on imem_gnt, fetch PC += 4 (wrapping at 2^32) and the FSM moves to WAIT.
REQ-018 WAIT: imem_req=0; on imem_rvalid, data SHALL load the decode register when !(valid_d && stall), then FETCH; otherwise it SHALL load the one-entry skid buffer, then SKID.
REQ-019 SKID: imem_req=0; when stall=0, skid contents SHALL move to the decode register, then FETCH.
REQ-020 Decode register SHALL hold when valid_d && stall; it SHALL clear valid_d when not stalled and no new data arrives.
REQ-021 redirect SHALL have priority over stall and every other event: fetch PC <= {redirect_pc[31:2],2'b00}, valid_d <= 0, skid emptied.
REQ-022 redirect in WAIT without imem_rvalid SHALL go to DROP; DROP discards the next imem_rvalid, then FETCH.
REQ-023 redirect coincident with imem_rvalid SHALL discard that response and go to FETCH.
REQ-024 redirect in FETCH coincident with imem_gnt SHALL go to DROP (granted stale address discarded).
REQ-025 Latency: request granted in cycle N with rvalid in N+1 SHALL give valid_d=1 in N+2; back-to-back throughput SHALL be one instruction per two cycles.
REQ-026 When valid_d=0, instr_d SHALL be 32'h00000013 (NOP).

Reset
REQ-027 reset SHALL force: state FETCH, fetch PC RESET_PC, valid_d 0, instr_d 32'h00000013, pc_d 0, pcplus4_d 4, skid empty, imem_req 0 while reset is high.
REQ-028 reset asserted mid-transaction SHALL abandon the outstanding request; the first imem_rvalid after reset with no post-reset grant SHALL be ignored.

Structure
REQ-029 Shared package riscv_pkg SHALL hold the FSM state enum, the NOP constant 32'h00000013 and the RESET_PC default.
REQ-030 The skid buffer SHALL be one sub-module, fetch_skid_buf (data, pc, full flag, load/unload/clear).

Verification
REQ-031 Reset release with gnt tied 1, rvalid one cycle after gnt, rdata=32'h00500093 -> imem_addr 0 then 4; valid_d=1 with instr_d=32'h00500093, pc_d=0, pcplus4_d=4 two cycles after first gnt.
REQ-032 stall asserted while valid_d=1 and a response arrives -> decode outputs frozen; FSM enters SKID; no imem_req; stall release -> skid word appears next cycle with pc_d=4.
REQ-033 redirect with redirect_pc=32'h00000103 while in WAIT -> next rvalid discarded; next imem_addr=32'h00000100; valid_d=0 until the new response.
REQ-034 redirect and imem_rvalid in the same cycle, with stall=1 -> response dropped, valid_d=0, imem_addr=target next cycle.
REQ-035 RESET_PC=32'hFFFFFFFC -> first fetch at 32'hFFFFFFFC, second at 0; pcplus4_d=0 for the first instruction.
REQ-036 reset pulse while WAIT, then stale rvalid -> ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the canonical NOP
// and the default reset fetch address.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2,
    ST_SKID  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control from the pipeline, instruction-memory handshake
// and the decode-register outputs. master = fetch stage, slave = its environment.
interface fetch_stage_if;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  modport master (
    input  redirect, redirect_pc, stall,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output instr_d, pc_d, pcplus4_d, valid_d
  );

  modport slave (
    output redirect, redirect_pc, stall,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  instr_d, pc_d, pcplus4_d, valid_d
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer parking an instruction word and its address while
// the decode register is held by a stall.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic [31:0] o_data,
  output logic [31:0] o_pc,
  output logic        o_full
);

  logic        r_full;
  logic [31:0] r_data;
  logic [31:0] r_pc;

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  // NOTE: the payload is qualified by r_full, so it carries no reset and
  // can map onto plain, non-resettable flops.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
      r_pc   <= i_pc;
    end
  end

  assign o_data = r_data;
  assign o_pc   = r_pc;
  assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding request to instruction memory, a
// registered decode stage and a skid entry to absorb responses during stalls.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;

  logic        r_valid_d;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;

  logic        w_hold_d;
  logic        w_grant;
  logic        w_rsp_ok;
  logic        w_rsp_take;
  logic        w_rsp_skid;
  logic        w_skid_unload;
  logic [31:0] w_skid_data;
  logic [31:0] w_skid_pc;
  logic        w_skid_full;

  assign w_hold_d      = r_valid_d && bus.stall;
  assign bus.imem_req  = !reset && (r_state == ST_FETCH) && !w_hold_d;
  assign bus.imem_addr = r_fetch_pc;
  assign w_grant       = bus.imem_req && bus.imem_gnt;

  // A response is only ours in WAIT; DROP and post-reset FETCH swallow it.
  assign w_rsp_ok      = (r_state == ST_WAIT) && bus.imem_rvalid && !bus.redirect;
  assign w_rsp_take    = w_rsp_ok && !w_hold_d;
  assign w_rsp_skid    = w_rsp_ok && w_hold_d;
  assign w_skid_unload = (r_state == ST_SKID) && w_skid_full && !bus.stall && !bus.redirect;

  // NOTE: w_state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_grant) w_state_nxt = bus.redirect ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = (bus.redirect || !w_hold_d) ? ST_FETCH : ST_SKID;
        end else if (bus.redirect) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.imem_rvalid) w_state_nxt = ST_FETCH;
      end
      ST_SKID: begin
        if (bus.redirect || !bus.stall) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (bus.redirect) begin
      r_fetch_pc <= word_align(bus.redirect_pc);
    end else if (w_grant) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
      r_req_pc   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d   <= 1'b0;
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= 32'h00000000;
      r_pcplus4_d <= 32'h00000004;
    end else if (bus.redirect) begin
      r_valid_d <= 1'b0;
      r_instr_d <= NOP_INSTR;
    end else if (!w_hold_d) begin
      if (w_rsp_take) begin
        r_valid_d   <= 1'b1;
        r_instr_d   <= bus.imem_rdata;
        r_pc_d      <= r_req_pc;
        r_pcplus4_d <= r_req_pc + 32'd4;
      end else if (w_skid_unload) begin
        r_valid_d   <= 1'b1;
        r_instr_d   <= w_skid_data;
        r_pc_d      <= w_skid_pc;
        r_pcplus4_d <= w_skid_pc + 32'd4;
      end else begin
        r_valid_d <= 1'b0;
        r_instr_d <= NOP_INSTR;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_rsp_skid),
    .i_unload (w_skid_unload),
    .i_clear  (bus.redirect),
    .i_data   (bus.imem_rdata),
    .i_pc     (r_req_pc),
    .o_data   (w_skid_data),
    .o_pc     (w_skid_pc),
    .o_full   (w_skid_full)
  );

  assign bus.instr_d   = r_instr_d;
  assign bus.pc_d      = r_pc_d;
  assign bus.pcplus4_d = r_pcplus4_d;
  assign bus.valid_d   = r_valid_d;

endmodule
